clock_unit: RTL and testbench

- 24-hour time-of-day counter that stores hours, minutes and seconds as BCD digit pairs (tens and ones).
- Advances one second every TICKS_PER_SEC clock cycles.
- Can be preset (overwritten) from parallel BCD inputs.
- Sits under the alarm-clock top level and feeds the display and alarm-compare logic.

---
 rtl/clock_unit.sv | 61 ++++++
 tb/tb_clock_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/clock_unit.sv
// clock_unit: 24-hour BCD time-of-day counter with prescaler and validated preset
module clock_unit #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       time_ow,
    input  logic [3:0] sec_i_o,
    input  logic [3:0] sec_i_t,
    input  logic [3:0] min_i_o,
    input  logic [3:0] min_i_t,
    input  logic [3:0] hr_i_o,
    input  logic [3:0] hr_i_t,
    output logic [3:0] sec_o,
    output logic [3:0] sec_t,
    output logic [3:0] min_o,
    output logic [3:0] min_t,
    output logic [3:0] hr_o,
    output logic [3:0] hr_t
);
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    logic [PW-1:0] pre;
    logic tick, c1, c2, c3, c4, day_end, sec_ok, min_ok, hr_ok;
    // Carry chain of the BCD ripple and validity of each preset field
    always_comb begin
        tick    = pre == PW'(TICKS_PER_SEC - 1);
        c1      = tick && sec_o == 4'd9;
        c2      = c1 && sec_t == 4'd5;
        c3      = c2 && min_o == 4'd9;
        c4      = c3 && min_t == 4'd5;
        day_end = c4 && hr_t == 4'd2 && hr_o == 4'd3;
        sec_ok  = sec_i_t <= 4'd5 && sec_i_o <= 4'd9;
        min_ok  = min_i_t <= 4'd5 && min_i_o <= 4'd9;
        hr_ok   = hr_i_o <= 4'd9 && (hr_i_t < 4'd2 || (hr_i_t == 4'd2 && hr_i_o <= 4'd3));
    end
    // Digit and prescaler registers: reset, then preset, then counting
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            {hr_t, hr_o, min_t, min_o, sec_t, sec_o} <= '0;
        end else if (time_ow) begin
            pre <= '0;
            {sec_t, sec_o} <= sec_ok ? {sec_i_t, sec_i_o} : 8'h00;
            {min_t, min_o} <= min_ok ? {min_i_t, min_i_o} : 8'h00;
            {hr_t, hr_o}   <= hr_ok ? {hr_i_t, hr_i_o} : 8'h00;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) sec_o <= sec_o == 4'd9 ? 4'd0 : sec_o + 4'd1;
            if (c1) sec_t <= sec_t == 4'd5 ? 4'd0 : sec_t + 4'd1;
            if (c2) min_o <= min_o == 4'd9 ? 4'd0 : min_o + 4'd1;
            if (c3) min_t <= min_t == 4'd5 ? 4'd0 : min_t + 4'd1;
            if (day_end) begin
                hr_t <= 4'd0;
                hr_o <= 4'd0;
            end else if (c4) begin
                hr_o <= hr_o == 4'd9 ? 4'd0 : hr_o + 4'd1;
                if (hr_o == 4'd9) hr_t <= hr_t + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_clock_unit.sv
// tb_clock_unit: directed checks of reset, preset, ripple, hold, validation and prescaling
module tb_clock_unit;
    logic clk = 0, rst = 0, time_ow = 0;
    logic [23:0] pin = '0;
    logic [23:0] now1, now4;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    clock_unit dut1 (
        .clk(clk), .rst(rst), .time_ow(time_ow),
        .sec_i_o(pin[3:0]), .sec_i_t(pin[7:4]), .min_i_o(pin[11:8]),
        .min_i_t(pin[15:12]), .hr_i_o(pin[19:16]), .hr_i_t(pin[23:20]),
        .sec_o(now1[3:0]), .sec_t(now1[7:4]), .min_o(now1[11:8]),
        .min_t(now1[15:12]), .hr_o(now1[19:16]), .hr_t(now1[23:20])
    );

    clock_unit #(.TICKS_PER_SEC(4)) dut4 (
        .clk(clk), .rst(rst), .time_ow(time_ow),
        .sec_i_o(pin[3:0]), .sec_i_t(pin[7:4]), .min_i_o(pin[11:8]),
        .min_i_t(pin[15:12]), .hr_i_o(pin[19:16]), .hr_i_t(pin[23:20]),
        .sec_o(now4[3:0]), .sec_t(now4[7:4]), .min_o(now4[11:8]),
        .min_t(now4[15:12]), .hr_o(now4[19:16]), .hr_t(now4[23:20])
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [23:0] t);
        pin = t;
        time_ow = 1;
        edges(1);
        time_ow = 0;
    endtask

    initial begin
        pin = 24'h123456;
        time_ow = 1;
        edges(2);
        rst = 1;
        edges(1);
        check("reset", now1, 24'h000000);
        check("reset_p4", now4, 24'h000000);
        rst = 0;

        load(24'h233100);
        check("preset", now1, 24'h233100);
        edges(1);
        check("run_1", now1, 24'h233101);
        edges(59);
        check("run_60", now1, 24'h233200);

        load(24'h095959);
        edges(1);
        check("ripple_09", now1, 24'h100000);
        load(24'h195959);
        edges(1);
        check("ripple_19", now1, 24'h200000);
        load(24'h235959);
        edges(1);
        check("ripple_day", now1, 24'h000000);
        load(24'h120959);
        edges(1);
        check("ripple_min", now1, 24'h121000);

        pin = 24'h050607;
        time_ow = 1;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            check("hold", now1, 24'h050607);
        end
        time_ow = 0;
        edges(1);
        check("hold_release", now1, 24'h050608);

        pin = 24'h256134;
        time_ow = 1;
        edges(1);
        check("invalid_hm", now1, 24'h000034);
        pin = 24'h1A5970;
        edges(1);
        check("invalid_hs", now1, 24'h005900);

        load(24'h000058);
        check("p4_load", now4, 24'h000058);
        edges(3);
        check("p4_edge3", now4, 24'h000058);
        edges(1);
        check("p4_edge4", now4, 24'h000059);
        edges(3);
        check("p4_edge7", now4, 24'h000059);
        edges(1);
        check("p4_edge8", now4, 24'h000100);

        rst = 1;
        time_ow = 1;
        pin = 24'h111111;
        edges(1);
        check("reset_over_ow", now1, 24'h000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
